// File: rtl/usb_uart_in_coalescer_if.sv
`default_nettype none
// ============================================================================
//  Module   : usb_uart_in_coalescer_if
//  Purpose  : Bundles the user-side write port, the uart_in drain port and
//             the status outputs of the uart_in coalescer.
//  Revision : 1.0  initial release
// ============================================================================
interface usb_uart_in_coalescer_if #(
    parameter int DEPTH_LOG2 = 6
);
    // User-side byte stream
    logic [7:0]          wr_data;
    logic                wr_valid;
    logic                wr_ready;
    logic                flush;

    // Toward the USB serial core's uart_in pipeline
    logic [7:0]          uart_in_data;
    logic                uart_in_valid;
    logic                uart_in_ready;

    // Status
    logic [DEPTH_LOG2:0] level;
    logic                draining;

    // Environment / user logic side
    modport master (
        output wr_data, wr_valid, flush, uart_in_ready,
        input  wr_ready, uart_in_data, uart_in_valid, level, draining
    );

    // Coalescer side
    modport slave (
        input  wr_data, wr_valid, flush, uart_in_ready,
        output wr_ready, uart_in_data, uart_in_valid, level, draining
    );
endinterface
`default_nettype wire

// File: rtl/usb_uart_in_coalescer.sv
`default_nettype none
// ============================================================================
//  Module   : usb_uart_in_coalescer
//  Purpose  : Byte FIFO that holds user bytes until a threshold count, an
//             idle timeout or an explicit flush, then drains them back to
//             back into the uart_in pipeline so IN packets are filled.
//  Revision : 1.0  initial release
// ============================================================================
module usb_uart_in_coalescer #(
    parameter int DEPTH_LOG2 = 6,
    parameter int THRESH     = 32,
    parameter int TIMEOUT    = 48000
) (
    input  wire logic              clk_48mhz,
    input  wire logic              reset,      // active-low, synchronous
    usb_uart_in_coalescer_if.slave bus
);

    localparam int c_DEPTH = 2 ** DEPTH_LOG2;
    localparam int c_TW    = $clog2(TIMEOUT + 1);

    localparam logic [DEPTH_LOG2:0] c_DEPTH_CNT  = (DEPTH_LOG2 + 1)'(c_DEPTH);
    localparam logic [DEPTH_LOG2:0] c_THRESH_CNT = (DEPTH_LOG2 + 1)'(THRESH);
    localparam logic [DEPTH_LOG2:0] c_ONE_CNT    = (DEPTH_LOG2 + 1)'(1);
    localparam logic [c_TW-1:0]     c_TIMEOUT_T  = c_TW'(TIMEOUT);
    localparam logic [c_TW-1:0]     c_ONE_T      = c_TW'(1);

    typedef enum logic [0:0] {
        S_HOLD  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Storage and control state
    // ------------------------------------------------------------------------
    logic [7:0]            r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [c_TW-1:0]       r_timer;
    state_t                r_state;
    state_t                w_state_nxt;

    logic w_empty;
    logic w_wr_ready;
    logic w_valid;
    logic w_wr_acc;
    logic w_rd_acc;

    // Ready depends only on the registered fill level, never on the sink.
    assign w_empty    = (r_count == '0);
    assign w_wr_ready = (r_count < c_DEPTH_CNT);
    assign w_valid    = (r_state == S_DRAIN) && !w_empty;
    assign w_wr_acc   = bus.wr_valid && w_wr_ready;
    assign w_rd_acc   = w_valid && bus.uart_in_ready;

    // ------------------------------------------------------------------------
    // Outputs: first-word-fall-through from the read pointer. The read
    // pointer only moves on a read handshake, so data is stable while stalled.
    // ------------------------------------------------------------------------
    assign bus.wr_ready      = w_wr_ready;
    assign bus.uart_in_data  = r_mem[r_rd_ptr];
    assign bus.uart_in_valid = w_valid;
    assign bus.level         = r_count;
    assign bus.draining      = (r_state == S_DRAIN);

    // Byte storage; contents survive reset, only the pointers are cleared.
    always_ff @(posedge clk_48mhz) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= bus.wr_data;
        end
    end

    // Pointers and occupancy count; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk_48mhz) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + c_ONE_CNT;
                2'b01:   r_count <= r_count - c_ONE_CNT;
                default: r_count <= r_count;
            endcase
        end
    end

    // Idle timer: counts HOLD cycles since the last accepted write while
    // data is waiting, saturating so the timeout condition stays asserted.
    always_ff @(posedge clk_48mhz) begin
        if (!reset) begin
            r_timer <= '0;
        end else if (w_wr_acc || w_empty || (r_state == S_DRAIN)) begin
            r_timer <= '0;
        end else if (r_timer != c_TIMEOUT_T) begin
            r_timer <= r_timer + c_ONE_T;
        end
    end

    // State register.
    always_ff @(posedge clk_48mhz) begin
        if (!reset) begin
            r_state <= S_HOLD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: enter DRAIN on threshold, timeout or a useful flush;
    // leave once the last stored byte goes out with nothing new arriving.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_HOLD: begin
                if ((r_count >= c_THRESH_CNT) ||
                    (r_timer == c_TIMEOUT_T) ||
                    (bus.flush && (!w_empty || w_wr_acc))) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_empty ||
                    ((r_count == c_ONE_CNT) && w_rd_acc && !w_wr_acc)) begin
                    w_state_nxt = S_HOLD;
                end
            end
            default: w_state_nxt = S_HOLD;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_usb_uart_in_coalescer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_usb_uart_in_coalescer
//  Purpose  : Directed and random stimulus for the uart_in coalescer,
//             compared every cycle against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_usb_uart_in_coalescer;

    localparam int DL2   = 3;
    localparam int TH    = 4;
    localparam int TO    = 10;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    usb_uart_in_coalescer_if #(.DEPTH_LOG2(DL2)) bus ();

    usb_uart_in_coalescer #(
        .DEPTH_LOG2 (DL2),
        .THRESH     (TH),
        .TIMEOUT    (TO)
    ) u_dut (
        .clk_48mhz (clk),
        .reset     (rst_n),
        .bus       (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: stored bytes in order, drain mode, idle cycle count.
    byte unsigned q[$];
    bit           m_drn;
    int           m_idle;

    // Stall tracking for the data-stability check.
    bit           p_chk;
    byte unsigned p_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs produced by the previous edge, drive
    // new inputs, and advance the model to what the coming edge must do.
    task automatic step(input bit wv, input byte unsigned wd, input bit fl,
                        input bit rdy, input bit rn, output bit wacc);
        bit mv, mwr, ra, go, leave;
        int sz;
        @(negedge clk);
        sz  = q.size();
        mv  = m_drn && (sz > 0);
        mwr = (sz < DEPTH);
        chk("level",    32'(bus.level),    32'(sz));
        chk("valid",    32'(bus.uart_in_valid), 32'(mv));
        chk("draining", 32'(bus.draining), 32'(m_drn));
        chk("wr_ready", 32'(bus.wr_ready), 32'(mwr));
        if (mv) chk("data", 32'(bus.uart_in_data), 32'(q[0]));
        if (p_chk) begin
            chk("stall_valid", 32'(bus.uart_in_valid), 32'd1);
            chk("stall_data",  32'(bus.uart_in_data),  32'(p_data));
        end

        bus.wr_valid      = wv;
        bus.wr_data       = wd;
        bus.flush         = fl;
        bus.uart_in_ready = rdy;
        rst_n             = rn;

        wacc   = wv && mwr;
        ra     = mv && rdy;
        p_chk  = mv && !rdy && rn;
        p_data = mv ? q[0] : 8'h00;

        if (!rn) begin
            q.delete();
            m_drn  = 1'b0;
            m_idle = 0;
            wacc   = 1'b0;
        end else begin
            go    = (sz >= TH) || (m_idle >= TO) || (fl && (sz > 0 || wacc));
            leave = (sz == 0) || (sz == 1 && ra && !wacc);
            if (wacc || sz == 0 || m_drn) m_idle = 0;
            else if (m_idle < TO)         m_idle = m_idle + 1;
            m_drn = m_drn ? !leave : go;
            if (ra)   void'(q.pop_front());
            if (wacc) q.push_back(wd);
        end
    endtask

    task automatic idle(input int n, input bit rdy);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, rdy, 1'b1, a);
    endtask

    initial begin
        bit           a;
        int           idx;
        byte unsigned b;

        rst_n             = 1'b0;
        bus.wr_valid      = 1'b0;
        bus.wr_data       = 8'h00;
        bus.flush         = 1'b0;
        bus.uart_in_ready = 1'b1;
        m_drn  = 1'b0;
        m_idle = 0;
        p_chk  = 1'b0;

        // Reset held for one more edge; first check sees the reset state.
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, a);
        chk("reset_level", 32'(bus.level), 32'd0);

        // Threshold drain
        step(1'b1, 8'h11, 1'b0, 1'b1, 1'b1, a);
        step(1'b1, 8'h22, 1'b0, 1'b1, 1'b1, a);
        step(1'b1, 8'h33, 1'b0, 1'b1, 1'b1, a);
        step(1'b1, 8'h44, 1'b0, 1'b1, 1'b1, a);
        idle(8, 1'b1);

        // Timeout drain of a single byte
        step(1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, a);
        idle(15, 1'b1);

        // Flush with data, then flush on empty followed by a lone write
        step(1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, a);
        step(1'b1, 8'h6B, 1'b0, 1'b1, 1'b1, a);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, a);
        idle(5, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, a);
        idle(2, 1'b1);
        step(1'b1, 8'hC3, 1'b0, 1'b1, 1'b1, a);
        idle(14, 1'b1);

        // Full FIFO with back-pressure, then random stalls while draining
        idx = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, byte'(idx), 1'b0, 1'b0, 1'b1, a);
            if (a) idx++;
        end
        chk("full_level",    32'(bus.level),    32'(DEPTH));
        chk("full_wr_ready", 32'(bus.wr_ready), 32'd0);
        for (int i = 0; i < 80; i++) begin
            step(idx < 9, byte'(idx), 1'b0, ($urandom % 4) != 0, 1'b1, a);
            if (a) idx++;
        end
        chk("full_all_taken", 32'(idx), 32'd9);

        // Writes injected while a drain is in progress
        step(1'b1, 8'h81, 1'b0, 1'b1, 1'b1, a);
        step(1'b1, 8'h82, 1'b0, 1'b1, 1'b1, a);
        step(1'b1, 8'h83, 1'b0, 1'b1, 1'b1, a);
        step(1'b1, 8'h84, 1'b0, 1'b1, 1'b1, a);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, a);
        step(1'b1, 8'h85, 1'b0, 1'b1, 1'b1, a);
        step(1'b1, 8'h86, 1'b0, 1'b1, 1'b1, a);
        idle(10, 1'b1);

        // Reset in the middle of a drain with three bytes left
        for (int i = 0; i < 4; i++) step(1'b1, byte'(8'h90 + i), 1'b0, 1'b0, 1'b1, a);
        idle(2, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, a);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, a);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, a);
        chk("post_reset_level", 32'(bus.level), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b1, byte'(8'hE0 + i), 1'b0, 1'b1, 1'b1, a);
        idle(10, 1'b1);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            b = byte'($urandom);
            step(($urandom % 2) == 0, b, ($urandom % 40) == 0,
                 ($urandom % 3) != 0, ($urandom % 300) != 0, a);
        end
        idle(30, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/usb_uart_in_coalescer.md
Name: usb_uart_in_coalescer

Overview:
- Byte FIFO with packet-coalescing policy, sitting directly upstream of the USB serial core's uart_in pipeline (device→host direction).
- Accepts bytes from user logic and holds them until a threshold count, an idle timeout or an explicit flush.
- Then drains them back-to-back into uart_in_data/valid/ready, so the IN endpoint sends full packets rather than one byte per transaction.

Parameters:
- DEPTH_LOG2, 6, log2 of FIFO depth; DEPTH = 2**DEPTH_LOG2 bytes.
- THRESH, 32, queued-byte count that forces a drain; legal range 1..DEPTH.
- TIMEOUT, 48000, idle cycles after the last accepted write before a drain is forced (1 ms at 48 MHz); must be ≥1.

Ports:
- clk_48mhz  in  1  sole clock.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clk_48mhz.
- wr_data  in  8  byte from user logic.
- wr_valid  in  1  wr_data valid.
- wr_ready  out  1  FIFO can accept a byte.
- flush  in  1  single-cycle request to drain whatever is queued.
- uart_in_data  out  8  byte to the core's uart_in_data.
- uart_in_valid  out  1  to the core's uart_in_valid.
- uart_in_ready  in  1  from the core's uart_in_ready.
- level  out  DEPTH_LOG2+1  bytes currently stored.
- draining  out  1  high in DRAIN state.

Behaviour:
- Reset (reset==0 at an edge):
  - rd_ptr, wr_ptr and count go to 0; state goes to HOLD; timer goes to 0.
  - After the edge: uart_in_valid=0, draining=0, level=0, wr_ready=1.
  - FIFO memory contents are not cleared. A byte presented but not yet handshaken is discarded.
- Write accept: wr_valid && wr_ready at an edge.
  - wr_ready = (count < DEPTH), combinational from registered count only. It never depends on uart_in_ready.
  - Accepted writes are allowed in both states.
- Read accept: uart_in_valid && uart_in_ready at an edge.
- count update per edge: +1 (write only), −1 (read only), unchanged (both or neither). Pointers are DEPTH_LOG2 bits and wrap modulo DEPTH.
- Output path:
  - First-word-fall-through: uart_in_data = mem[rd_ptr].
  - uart_in_valid = (state==DRAIN) && (count>0).
  - While valid && !ready, uart_in_data must hold stable.
- level = count; draining = (state==DRAIN).
- Timer:
  - Saturating counter, width $clog2(TIMEOUT+1).
  - Cleared to 0 on any accepted write, and whenever count==0.
  - Otherwise increments each HOLD cycle, saturating at TIMEOUT.
  - Held at 0 in DRAIN.
- State machine, 2 states:
  - HOLD→DRAIN at an edge when any of:
    - count ≥ THRESH;
    - timer == TIMEOUT;
    - flush==1 and (count>0 or a write is accepted that same edge).
  - flush with empty FIFO and no write is ignored and is not remembered.
  - DRAIN→HOLD at an edge when count==1 and a read is accepted with no simultaneous write, or when count==0.
  - Otherwise DRAIN persists; writes arriving during DRAIN extend the drain.
- Latencies:
  - Threshold: uart_in_valid rises one cycle after count first reaches THRESH.
  - Timeout: uart_in_valid rises TIMEOUT+1 edges after the edge that accepted the last write.
  - Flush: uart_in_valid rises one cycle after flush is sampled.
- Full: count==DEPTH → wr_ready=0. count ≥ THRESH also holds (THRESH ≤ DEPTH), so DRAIN is guaranteed and there is no deadlock.
- Simultaneous write and read at count==DEPTH cannot occur, because wr_ready=0.
- Simultaneous write and read at count==0 cannot occur, because uart_in_valid=0.
- No data loss or duplication under any uart_in_ready pattern. Bytes are emitted in exact write order.

Test Plan:
1. Threshold drain (DEPTH_LOG2=3, THRESH=4, TIMEOUT=10), uart_in_ready=1: write 0x11,0x22,0x33,0x44 on consecutive cycles → valid low through the 4th write edge; valid high the next cycle; bytes 0x11..0x44 on 4 consecutive cycles; then valid=0, draining=0, level=0.
2. Timeout: write 0xA5 only → valid stays 0 for 10 edges after the write; rises at edge 11; one byte 0xA5; back to HOLD.
3. Flush and empty flush:
   - 2 bytes queued, pulse flush → valid next cycle, both bytes out.
   - flush with level=0 → no state change; a later single write waits the full TIMEOUT.
4. Full/backpressure: uart_in_ready=0, write 9 bytes 0x00..0x08 with wr_valid held →
   - wr_ready drops after 8 accepts; level=8; valid high.
   - Raise ready with random stalls → output 0x00..0x07 in order, data stable during stalls.
   - 0x08 then accepted once wr_ready rises.
5. Write during drain: start a drain of 4 bytes; inject 2 more writes mid-drain → all 6 emitted contiguously in order before DRAIN→HOLD.
6. Reset mid-drain: assert reset=0 for one edge with level=3 and valid high → next cycle valid=0, level=0, wr_ready=1, state HOLD. A subsequent 4-byte burst drains correctly from pointer 0.
